// File: rtl/plus3_paging_sync.sv
// +2A/+3 paging manager: glitch-filtered I/O write capture into the 7FFD/1FFD
// registers, 16K slot-to-page resolution and DivMMC SRAM ROM-shadow select.
`timescale 1ns/1ps
module plus3_paging_sync #(
    parameter int unsigned         HIADDR_W    = 6,
    parameter logic [HIADDR_W-1:0] ROM_BASE    = 6'b111000,
    parameter bit                  MACHINE     = 1'b1,
    parameter bit                  FULL_DECODE = 1'b1,
    parameter int unsigned         MIN_LOW     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         a,
    input  logic                mreq_n,
    input  logic                iorq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [7:0]          din,
    output logic                allramplus3,
    output logic [1:0]          banco_rom,
    output logic [2:0]          slot_page,
    output logic                slot_is_rom,
    output logic                port_locked,
    output logic                sram_cs,
    output logic [HIADDR_W-1:0] sram_hiaddr
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_COMMIT} state_t;

    localparam logic [2:0] MIN_LOW_C = 3'(MIN_LOW);

    // Bus sampled together with w so the captured address/data align with the strobe.
    logic       w_q;
    logic [4:0] a_s_q;
    logic [5:0] din_s_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] cap_a_q, cap_a_d;
    logic [5:0] cap_d_q, cap_d_d;
    logic [5:0] bank128_q, bank128_d;
    logic [2:0] bankplus3_q, bankplus3_d;

    logic hit7, hit1;
    logic [1:0] slot_sel;
    logic unused_bits;

    assign unused_bits = ^{a[11:2], a[0], din[7:6]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q         <= 1'b1;
            a_s_q       <= '0;
            din_s_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_a_q     <= '0;
            cap_d_q     <= '0;
            bank128_q   <= '0;
            bankplus3_q <= '0;
        end else begin
            w_q         <= iorq_n | wr_n;
            a_s_q       <= {a[15:12], a[1]};
            din_s_q     <= din[5:0];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_a_q     <= cap_a_d;
            cap_d_q     <= cap_d_d;
            bank128_q   <= bank128_d;
            bankplus3_q <= bankplus3_d;
        end
    end

    // cap_a_q layout: {a[15:12], a[1]}
    always_comb begin
        hit7 = 1'b0;
        hit1 = 1'b0;
        if (FULL_DECODE) begin
            hit7 = (cap_a_q[4:3] == 2'b01) && !cap_a_q[0];
        end else begin
            hit7 = !cap_a_q[4] && !cap_a_q[0];
        end
        hit1 = MACHINE && (cap_a_q[4:1] == 4'b0001) && !cap_a_q[0] && !hit7;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_a_d     = cap_a_q;
        cap_d_d     = cap_d_q;
        bank128_d   = bank128_q;
        bankplus3_d = bankplus3_q;
        case (state_q)
            S_IDLE: begin
                if (!w_q) begin
                    state_d = S_LOW;
                    cnt_d   = 3'd1;
                    cap_a_d = a_s_q;
                    cap_d_d = din_s_q;
                end
            end
            S_LOW: begin
                if (!w_q) begin
                    if (cnt_q != 3'd7) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    cap_a_d = a_s_q;
                    cap_d_d = din_s_q;
                end else if (cnt_q >= MIN_LOW_C) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                if (!bank128_q[5]) begin
                    if (hit7) begin
                        bank128_d = cap_d_q;
                    end else if (hit1) begin
                        bankplus3_d = cap_d_q[2:0];
                    end
                end
                if (!w_q) begin
                    state_d = S_LOW;
                    cnt_d   = 3'd1;
                    cap_a_d = a_s_q;
                    cap_d_d = din_s_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        slot_sel    = a[15:14];
        allramplus3 = bankplus3_q[0];
        banco_rom   = {(MACHINE ? bankplus3_q[2] : 1'b0), bank128_q[4]};
        port_locked = bank128_q[5];
        slot_is_rom = (slot_sel == 2'b00) && !bankplus3_q[0];
        slot_page   = '0;
        if (!bankplus3_q[0]) begin
            case (slot_sel)
                2'b01:   slot_page = 3'd5;
                2'b10:   slot_page = 3'd2;
                2'b11:   slot_page = bank128_q[2:0];
                default: slot_page = '0;
            endcase
        end else begin
            case (bankplus3_q[2:1])
                2'b00:   slot_page = {1'b0, slot_sel};
                2'b01:   slot_page = {1'b1, slot_sel};
                2'b10:   slot_page = (slot_sel == 2'b11) ? 3'd3 : {1'b1, slot_sel};
                default: begin
                    case (slot_sel)
                        2'b00:   slot_page = 3'd4;
                        2'b01:   slot_page = 3'd7;
                        2'b10:   slot_page = 3'd6;
                        default: slot_page = 3'd3;
                    endcase
                end
            endcase
        end
        sram_cs     = !mreq_n && !rd_n && slot_is_rom;
        sram_hiaddr = {ROM_BASE[HIADDR_W-1:3], banco_rom, a[13]};
    end

endmodule

// File: tb/tb_plus3_paging_sync.sv
// Bench for plus3_paging_sync: table vectors, hand sequences for timing corners,
// and random writes checked against a behavioural paging model.
`timescale 1ns/1ps
module tb_plus3_paging_sync;

    localparam int MIN_LOW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic [7:0]  din;

    logic       alr [2];
    logic [1:0] br  [2];
    logic [2:0] pg  [2];
    logic       rom [2];
    logic       lck [2];
    logic       cs  [2];
    logic [5:0] hi  [2];

    int total = 0;
    int bad   = 0;

    // Behavioural model state: index 0 = full decode, 1 = partial decode.
    logic [5:0] m_b128 [2];
    logic [2:0] m_p3   [2];
    int MAPS [4][4] = '{'{0,1,2,3}, '{4,5,6,7}, '{4,5,6,3}, '{4,7,6,3}};

    typedef struct {
        logic [7:0]  d7;
        logic [7:0]  d1;
        logic [15:0] addr;
        logic        mq;
        logic        rd;
        logic        e_alr;
        logic        e_rom;
        logic [2:0]  e_pg;
        logic        e_cs;
        logic [5:0]  e_hi;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    plus3_paging_sync #(.HIADDR_W(6), .ROM_BASE(6'b111000), .MACHINE(1'b1),
                        .FULL_DECODE(1'b1), .MIN_LOW(MIN_LOW)) u_fd (
        .clk(clk), .rst_n(rst_n), .a(a), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .din(din),
        .allramplus3(alr[0]), .banco_rom(br[0]), .slot_page(pg[0]),
        .slot_is_rom(rom[0]), .port_locked(lck[0]), .sram_cs(cs[0]),
        .sram_hiaddr(hi[0])
    );

    plus3_paging_sync #(.HIADDR_W(6), .ROM_BASE(6'b111000), .MACHINE(1'b1),
                        .FULL_DECODE(1'b0), .MIN_LOW(MIN_LOW)) u_pd (
        .clk(clk), .rst_n(rst_n), .a(a), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .din(din),
        .allramplus3(alr[1]), .banco_rom(br[1]), .slot_page(pg[1]),
        .slot_is_rom(rom[1]), .port_locked(lck[1]), .sram_cs(cs[1]),
        .sram_hiaddr(hi[1])
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] act_word(input int i);
        return {alr[i], br[i], lck[i], rom[i], pg[i], cs[i], hi[i]};
    endfunction

    function automatic logic [14:0] model_word(input int i);
        int slot;
        logic allr, isrom, csx;
        logic [2:0] page;
        logic [5:0] hix;
        slot  = int'(a[15:14]);
        allr  = m_p3[i][0];
        isrom = (slot == 0) && !allr;
        if (isrom)          page = 3'd0;
        else if (!allr)     page = (slot == 1) ? 3'd5 : (slot == 2) ? 3'd2 : m_b128[i][2:0];
        else                page = 3'(MAPS[int'(m_p3[i][2:1])][slot]);
        csx = !mreq_n && !rd_n && isrom;
        hix = 6'(6'h38 + (m_p3[i][2] ? 4 : 0) + (m_b128[i][4] ? 2 : 0) + (a[13] ? 1 : 0));
        return {allr, m_p3[i][2], m_b128[i][4], m_b128[i][5], isrom, page, csx, hix};
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [7:0] data);
        for (int i = 0; i < 2; i++) begin
            logic is7, is1;
            if (m_b128[i][5]) continue;
            is7 = !addr[1] && ((i == 0) ? (addr[15:14] == 2'b01) : !addr[15]);
            is1 = !addr[1] && (addr[15:12] == 4'b0001);
            if (is7)      m_b128[i] = data[5:0];
            else if (is1) m_p3[i]   = data[2:0];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_b128[i] = '0;
            m_p3[i]   = '0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Low pulse of n clocks, then three idle clocks so any commit is visible.
    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int n);
        @(negedge clk);
        a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (n) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        if (n >= MIN_LOW) model_write(addr, data);
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic mq, input logic rd);
        a = addr; mreq_n = mq; rd_n = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; a = '0; din = '0;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.fd", act_word(0), {1'b0, 2'b00, 1'b0, 1'b1, 3'd0, 1'b0, 6'b111000});
        chk("reset.pd", act_word(1), {1'b0, 2'b00, 1'b0, 1'b1, 3'd0, 1'b0, 6'b111000});
        rst_n = 1'b1;

        // 3-clk write: not visible during COMMIT, visible the clock after.
        @(negedge clk);
        a = 16'h7FFD; din = 8'h13; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1.early", 15'(br[0]), 15'(2'b00));
        @(negedge clk);
        chk("t1.banco", 15'(br[0]), 15'(2'b01));
        model_write(16'h7FFD, 8'h13);
        bus_read(16'hC000, 1'b0, 1'b0);
        chk("t1.page3", 15'(pg[0]), 15'(3'd3));

        io_write(16'h7FFD, 8'h07, 1);
        bus_read(16'hC000, 1'b0, 1'b0);
        chk("t2.glitch", 15'(pg[0]), 15'(3'd3));
        chk("t2.word", act_word(0), model_word(0));

        io_write(16'h7FFD, 8'h20, 2);
        io_write(16'h7FFD, 8'h07, 2);
        io_write(16'h1FFD, 8'h05, 2);
        bus_read(16'hC000, 1'b0, 1'b0);
        chk("t3.locked", 15'(lck[0]), 15'(1'b1));
        chk("t3.frozen", {alr[0], br[0], pg[0]}, 15'({1'b0, 2'b00, 3'd0}));
        do_reset();
        #1;
        chk("t3.unlock", 15'(lck[0]), 15'(1'b0));

        // Reset asserted mid-write discards the write.
        @(negedge clk);
        a = 16'h7FFD; din = 8'h10; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rstmid.banco", 15'(br[0]), 15'(2'b00));

        // Back-to-back: second strobe begins while first is in COMMIT.
        @(negedge clk);
        a = 16'h7FFD; din = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        a = 16'h1FFD; din = 8'h04; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        model_write(16'h7FFD, 8'h01);
        model_write(16'h1FFD, 8'h04);
        bus_read(16'hC000, 1'b0, 1'b0);
        chk("b2b.page3", 15'(pg[0]), 15'(3'd1));
        chk("b2b.banco", 15'(br[0]), 15'(2'b10));
        mreq_n = 1'b1; rd_n = 1'b1;

        do_reset();
        vecs[0]  = '{8'h00, 8'h01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 6'h38};
        vecs[1]  = '{8'h00, 8'h01, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 6'h38};
        vecs[2]  = '{8'h00, 8'h01, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 6'h38};
        vecs[3]  = '{8'h00, 8'h01, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 6'h38};
        vecs[4]  = '{8'h00, 8'h03, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 6'h38};
        vecs[5]  = '{8'h00, 8'h03, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 6'h38};
        vecs[6]  = '{8'h00, 8'h03, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 6'h38};
        vecs[7]  = '{8'h00, 8'h03, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 6'h38};
        vecs[8]  = '{8'h00, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 6'h3C};
        vecs[9]  = '{8'h00, 8'h05, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 6'h3C};
        vecs[10] = '{8'h00, 8'h05, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 6'h3C};
        vecs[11] = '{8'h00, 8'h05, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 6'h3C};
        vecs[12] = '{8'h00, 8'h07, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 6'h3C};
        vecs[13] = '{8'h00, 8'h07, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 6'h3C};
        vecs[14] = '{8'h00, 8'h07, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 6'h3C};
        vecs[15] = '{8'h00, 8'h07, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 6'h3C};
        vecs[16] = '{8'h10, 8'h04, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 6'h3F};
        vecs[17] = '{8'h10, 8'h04, 16'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 6'h3F};
        vecs[18] = '{8'h03, 8'h00, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 6'h38};
        vecs[19] = '{8'h03, 8'h00, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 6'h38};
        vecs[20] = '{8'h03, 8'h00, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 6'h38};
        vecs[21] = '{8'h03, 8'h00, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 6'h39};
        for (int v = 0; v < 22; v++) begin
            io_write(16'h7FFD, vecs[v].d7, 2);
            io_write(16'h1FFD, vecs[v].d1, 2);
            bus_read(vecs[v].addr, vecs[v].mq, vecs[v].rd);
            chk($sformatf("vec%0d", v), {alr[0], rom[0], pg[0], cs[0], hi[0]},
                {vecs[v].e_alr, vecs[v].e_rom, vecs[v].e_pg, vecs[v].e_cs, vecs[v].e_hi});
            mreq_n = 1'b1; rd_n = 1'b1;
        end

        // Partial decode: 0x1FFD also matches 7FFD, which wins.
        do_reset();
        io_write(16'h1FFD, 8'h04, 3);
        bus_read(16'hC000, 1'b0, 1'b0);
        chk("t6.pd", {alr[1], br[1], pg[1]}, 15'({1'b0, 2'b00, 3'd4}));
        chk("t6.fd", {alr[0], br[0], pg[0]}, 15'({1'b0, 2'b10, 3'd0}));
        mreq_n = 1'b1; rd_n = 1'b1;

        for (int it = 0; it < 300; it++) begin
            logic [15:0] addr;
            logic [7:0]  data;
            int sel;
            if ($urandom_range(0, 19) == 0) do_reset();
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: addr = 16'h7FFD;
                1: addr = 16'h1FFD;
                2: addr = 16'h3FFD;
                3: addr = 16'h0FFD;
                default: addr = 16'($urandom);
            endcase
            data = 8'($urandom);
            if ($urandom_range(0, 7) != 0) data[5] = 1'b0;
            io_write(addr, data, int'($urandom_range(1, 4)));
            for (int r = 0; r < 2; r++) begin
                bus_read(16'($urandom), 1'($urandom), 1'($urandom));
                chk($sformatf("rnd%0d.fd", it), act_word(0), model_word(0));
                chk($sformatf("rnd%0d.pd", it), act_word(1), model_word(1));
            end
            mreq_n = 1'b1; rd_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
